// File: rtl/mem_arb_if.sv
// Bus bundle between the masters, the mem_arb arbiter and the slave.
// The m_lock_i input exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arb_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  localparam int BW = DW / 8;

  logic [NUM_MASTERS-1:0]    m_req_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS*AW-1:0] m_addr_bi;
  logic [NUM_MASTERS*DW-1:0] m_wdata_bi;
  logic [NUM_MASTERS*BW-1:0] m_be_bi;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_resp_o;
  logic [DW-1:0]             m_rdata_bo;
  logic                      s_req_o;
  logic                      s_we_o;
  logic [AW-1:0]             s_addr_bo;
  logic [DW-1:0]             s_wdata_bo;
  logic [BW-1:0]             s_be_bo;
  logic [DW-1:0]             s_rdata_bi;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0]    m_lock_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_bi, m_wdata_bi, m_be_bi, m_lock_i, s_rdata_bi,
    output m_ack_o, m_resp_o, m_rdata_bo, s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo
  );
  modport master (
    output m_req_i, m_we_i, m_addr_bi, m_wdata_bi, m_be_bi, m_lock_i, s_rdata_bi,
    input  m_ack_o, m_resp_o, m_rdata_bo, s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo
  );
`else
  modport slave (
    input  m_req_i, m_we_i, m_addr_bi, m_wdata_bi, m_be_bi, s_rdata_bi,
    output m_ack_o, m_resp_o, m_rdata_bo, s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo
  );
  modport master (
    output m_req_i, m_we_i, m_addr_bi, m_wdata_bi, m_be_bi, s_rdata_bi,
    input  m_ack_o, m_resp_o, m_rdata_bo, s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo
  );
`endif
endinterface

// File: rtl/mem_arb.sv
// N-master to 1-slave memory arbiter, fixed-priority or round-robin, combinational grant.
// Optional grant locking is enabled with macro MEM_ARB_LOCK_EN.
module mem_arb #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RR_EN       = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mem_arb_if.slave bus
);
  localparam int            BW       = DW / 8;
  localparam int            IW       = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] resp_q, resp_d;
  logic [NUM_MASTERS-1:0] req_eff;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [IW-1:0]          gnt_idx;
  logic                   gnt_vld;
  logic                   gnt_we;

  // Requests are masked while in reset so nothing reaches the slave.
  assign req_eff = rst_i ? bus.m_req_i : '0;

`ifdef MEM_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0] prev_gnt_q, prev_gnt_d;
  logic [NUM_MASTERS-1:0] lock_hit;

  assign lock_hit = prev_gnt_q & req_eff & bus.m_lock_i;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [IW-1:0] cidx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cidx    = '0;
    if (RR_EN != 0) begin
      // Walk offsets from farthest to nearest so the nearest requester after last_q wins.
      for (int i = NUM_MASTERS; i >= 1; i--) begin
        cidx = IW'((int'(last_q) + i) % NUM_MASTERS);
        if (req_eff[cidx]) begin
          gnt_vld = 1'b1;
          gnt_idx = cidx;
        end
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req_eff[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end
`ifdef MEM_ARB_LOCK_EN
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (lock_hit[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    end
`endif
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    gnt_we = gnt_vld & bus.m_we_i[gnt_idx];
  end

  always_comb begin
    bus.s_req_o    = gnt_vld;
    bus.s_we_o     = gnt_we;
    bus.s_addr_bo  = '0;
    bus.s_wdata_bo = '0;
    bus.s_be_bo    = '0;
    if (gnt_vld) begin
      bus.s_addr_bo  = bus.m_addr_bi [int'(gnt_idx)*AW +: AW];
      bus.s_wdata_bo = bus.m_wdata_bi[int'(gnt_idx)*DW +: DW];
      bus.s_be_bo    = bus.m_be_bi   [int'(gnt_idx)*BW +: BW];
    end
  end

  assign bus.m_ack_o    = gnt_oh;
  assign bus.m_resp_o   = resp_q;
  assign bus.m_rdata_bo = bus.s_rdata_bi;

  always_comb begin
    last_d = gnt_vld ? gnt_idx : last_q;
    resp_d = (gnt_vld && !gnt_we) ? gnt_oh : '0;
`ifdef MEM_ARB_LOCK_EN
    prev_gnt_d = gnt_oh;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q     <= LAST_RST;
      resp_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
      prev_gnt_q <= '0;
`endif
    end else begin
      last_q     <= last_d;
      resp_q     <= resp_d;
`ifdef MEM_ARB_LOCK_EN
      prev_gnt_q <= prev_gnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a 2-master fixed-priority instance and a 4-master round-robin one.
// Lock sequences run only when MEM_ARB_LOCK_EN is defined.
module tb_mem_arb;
  localparam logic [31:0] WD1 = 32'h1111_1111;
  localparam logic [3:0]  BE1 = 4'hC;

  logic clk = 1'b0;
  logic rst_i;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.NUM_MASTERS(2), .AW(32), .DW(32)) bus_fp ();
  mem_arb_if #(.NUM_MASTERS(4), .AW(32), .DW(32)) bus_rr ();

  mem_arb #(.NUM_MASTERS(2), .AW(32), .DW(32), .RR_EN(0)) dut_fp (
    .clk_i(clk), .rst_i(rst_i), .bus(bus_fp)
  );
  mem_arb #(.NUM_MASTERS(4), .AW(32), .DW(32), .RR_EN(1)) dut_rr (
    .clk_i(clk), .rst_i(rst_i), .bus(bus_rr)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic [31:0] srd;
    logic [1:0]  ack;
    logic [1:0]  resp;
    logic        sreq;
    logic        swe;
    logic [31:0] saddr;
    logic [31:0] swd;
    logic [3:0]  sbe;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_fp(input logic [1:0] req, input logic [1:0] we, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [31:0] wd0, input logic [3:0] be0,
                          input logic [31:0] srd);
    bus_fp.m_req_i    = req;
    bus_fp.m_we_i     = we;
    bus_fp.m_addr_bi  = {a1, a0};
    bus_fp.m_wdata_bi = {WD1, wd0};
    bus_fp.m_be_bi    = {BE1, be0};
    bus_fp.s_rdata_bi = srd;
  endtask

  task automatic rr_step(input string tag, input logic [3:0] req, input logic [3:0] lock,
                         input logic [3:0] exp_ack, input logic [3:0] exp_resp);
    logic [31:0] exp_addr;
    @(posedge clk);
    #1;
    bus_rr.m_req_i = req;
`ifdef MEM_ARB_LOCK_EN
    bus_rr.m_lock_i = lock;
`endif
    @(negedge clk);
    exp_addr = 32'h0;
    for (int k = 0; k < 4; k++) if (exp_ack[k]) exp_addr = 32'(k) * 32'h1000;
    check({tag, "_ack"},  32'(bus_rr.m_ack_o),  32'(exp_ack));
    check({tag, "_resp"}, 32'(bus_rr.m_resp_o), 32'(exp_resp));
    check({tag, "_addr"}, bus_rr.s_addr_bo,     exp_addr);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,         4'h0, 32'h55,
                 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0};
    vecs[1]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'hCAFE_0001, 4'hF, 32'h0,
                 2'b01, 2'b00, 1'b1, 1'b0, 32'h100, 32'hCAFE_0001, 4'hF};
    vecs[2]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'hCAFE_0001, 4'hF, 32'h0,
                 2'b01, 2'b01, 1'b1, 1'b0, 32'h100, 32'hCAFE_0001, 4'hF};
    vecs[3]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'hCAFE_0001, 4'hF, 32'h0,
                 2'b01, 2'b01, 1'b1, 1'b0, 32'h100, 32'hCAFE_0001, 4'hF};
    vecs[4]  = '{2'b10, 2'b00, 32'h100, 32'h10,  32'hCAFE_0001, 4'hF, 32'h0,
                 2'b10, 2'b01, 1'b1, 1'b0, 32'h10,  WD1,           BE1};
    vecs[5]  = '{2'b01, 2'b00, 32'h20,  32'h10,  32'hCAFE_0001, 4'hF, 32'hAAAA_0010,
                 2'b01, 2'b10, 1'b1, 1'b0, 32'h20,  32'hCAFE_0001, 4'hF};
    vecs[6]  = '{2'b00, 2'b00, 32'h20,  32'h10,  32'hCAFE_0001, 4'hF, 32'hBBBB_0020,
                 2'b00, 2'b01, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0};
    vecs[7]  = '{2'b01, 2'b01, 32'h8,   32'h10,  32'hDEAD_BEEF, 4'h3, 32'h0,
                 2'b01, 2'b00, 1'b1, 1'b1, 32'h8,   32'hDEAD_BEEF, 4'h3};
    vecs[8]  = '{2'b00, 2'b00, 32'h8,   32'h10,  32'hDEAD_BEEF, 4'h3, 32'h0,
                 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0};
    vecs[9]  = '{2'b10, 2'b10, 32'h8,   32'h44,  32'hDEAD_BEEF, 4'h3, 32'h0,
                 2'b10, 2'b00, 1'b1, 1'b1, 32'h44,  WD1,           BE1};
    vecs[10] = '{2'b00, 2'b00, 32'h8,   32'h44,  32'hDEAD_BEEF, 4'h3, 32'h0,
                 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0};

    // Reset held with every master requesting: outputs must stay quiet.
    rst_i = 1'b0;
    drive_fp(2'b11, 2'b00, 32'h100, 32'h200, 32'h1, 4'hF, 32'h0);
    bus_rr.m_req_i    = 4'b1111;
    bus_rr.m_we_i     = 4'b0000;
    bus_rr.m_addr_bi  = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
    bus_rr.m_wdata_bi = '0;
    bus_rr.m_be_bi    = '1;
    bus_rr.s_rdata_bi = 32'h0;
`ifdef MEM_ARB_LOCK_EN
    bus_rr.m_lock_i   = 4'b0000;
`endif
    repeat (2) @(negedge clk);
    check("rst_fp_ack",  32'(bus_fp.m_ack_o),  32'h0);
    check("rst_fp_resp", 32'(bus_fp.m_resp_o), 32'h0);
    check("rst_fp_sreq", 32'(bus_fp.s_req_o),  32'h0);
    check("rst_fp_addr", bus_fp.s_addr_bo,     32'h0);
    check("rst_rr_ack",  32'(bus_rr.m_ack_o),  32'h0);
    check("rst_rr_sreq", 32'(bus_rr.s_req_o),  32'h0);
    bus_rr.m_req_i = 4'b0000;
    drive_fp(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    rst_i = 1'b1;

    // Fixed-priority table: one row per cycle, resp reflects the previous row.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      drive_fp(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].be0, vecs[i].srd);
      @(negedge clk);
      check($sformatf("v%0d_ack", i),   32'(bus_fp.m_ack_o),  32'(vecs[i].ack));
      check($sformatf("v%0d_resp", i),  32'(bus_fp.m_resp_o), 32'(vecs[i].resp));
      check($sformatf("v%0d_sreq", i),  32'(bus_fp.s_req_o),  32'(vecs[i].sreq));
      check($sformatf("v%0d_swe", i),   32'(bus_fp.s_we_o),   32'(vecs[i].swe));
      check($sformatf("v%0d_saddr", i), bus_fp.s_addr_bo,     vecs[i].saddr);
      check($sformatf("v%0d_swd", i),   bus_fp.s_wdata_bo,    vecs[i].swd);
      check($sformatf("v%0d_sbe", i),   32'(bus_fp.s_be_bo),  32'(vecs[i].sbe));
      check($sformatf("v%0d_rdata", i), bus_fp.m_rdata_bo,    vecs[i].srd);
    end

    // Round-robin: everyone requesting from reset rotates 0,1,2,3,0.
    rr_step("rr0", 4'b1111, 4'b0000, 4'b0001, 4'b0000);
    rr_step("rr1", 4'b1111, 4'b0000, 4'b0010, 4'b0001);
    rr_step("rr2", 4'b1111, 4'b0000, 4'b0100, 4'b0010);
    rr_step("rr3", 4'b1111, 4'b0000, 4'b1000, 4'b0100);
    rr_step("rr4", 4'b1111, 4'b0000, 4'b0001, 4'b1000);
    // Sparse requests: the search skips idle masters and wraps 3 -> 1.
    rr_step("rr5", 4'b1010, 4'b0000, 4'b0010, 4'b0001);
    rr_step("rr6", 4'b1010, 4'b0000, 4'b1000, 4'b0010);
    rr_step("rr7", 4'b1010, 4'b0000, 4'b0010, 4'b1000);
`ifdef MEM_ARB_LOCK_EN
    // m2 wins by rotation, then holds through lock, then the pointer moves on to m0.
    rr_step("lk0", 4'b0111, 4'b0100, 4'b0100, 4'b0010);
    rr_step("lk1", 4'b0111, 4'b0100, 4'b0100, 4'b0100);
    rr_step("lk2", 4'b0111, 4'b0100, 4'b0100, 4'b0100);
    rr_step("lk3", 4'b0011, 4'b0000, 4'b0001, 4'b0100);
    rr_step("lk4", 4'b0110, 4'b0000, 4'b0010, 4'b0001);
`endif
    rr_step("rr_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0010);

    // Reset asserted while an m0 read is being granted: no response follows.
    @(posedge clk);
    #1;
    drive_fp(2'b01, 2'b00, 32'h30, 32'h0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    check("pre_rst_ack", 32'(bus_fp.m_ack_o), 32'h1);
    rst_i = 1'b0;
    #1;
    check("in_rst_ack",  32'(bus_fp.m_ack_o), 32'h0);
    check("in_rst_sreq", 32'(bus_fp.s_req_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("in_rst_resp", 32'(bus_fp.m_resp_o), 32'h0);
    check("in_rst_ack2", 32'(bus_fp.m_ack_o),  32'h0);
    bus_fp.m_req_i = 2'b11;
    bus_rr.m_req_i = 4'b1111;
    rst_i = 1'b1;
    #1;
    check("post_rst_fp_ack", 32'(bus_fp.m_ack_o), 32'h1);
    check("post_rst_rr_ack", 32'(bus_rr.m_ack_o), 32'h1);
    check("post_rst_resp",   32'(bus_fp.m_resp_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, giving the number of master ports, legal range 2..8.
REQ-002 The block SHALL have parameter AW, default 32, giving the address width.
REQ-003 The block SHALL have parameter DW, default 32, giving the data width, a multiple of 8; BW = DW/8.
REQ-004 The block SHALL have parameter RR_EN, default 0, selecting arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-005 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-006 Ports, in order:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_bi  in  NUM_MASTERS*AW  packed addresses; master k at [k*AW +: AW].
- m_wdata_bi  in  NUM_MASTERS*DW  packed write data.
- m_be_bi  in  NUM_MASTERS*BW  packed byte enables.
- m_ack_o  out  NUM_MASTERS  one-hot request accept.
- m_resp_o  out  NUM_MASTERS  one-hot read-data-valid.
- m_rdata_bo  out  DW  shared read data, qualified by m_resp_o.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_bo  out  AW  slave address.
- s_wdata_bo  out  DW  slave write data.
- s_be_bo  out  BW  slave byte enables.
- s_rdata_bi  in  DW  slave read data, valid exactly 1 cycle after an accepted read.

Function
REQ-007 The slave SHALL be treated as always-ready: every cycle with s_req_o=1 is an accepted transfer.
REQ-008 Grant SHALL be combinational: in any cycle with at least one m_req_i bit set, exactly one master g is granted, s_req_o=1, s_we/addr/wdata/be = master g's fields, m_ack_o = one-hot g.
REQ-009 With no request, s_req_o=0, m_ack_o=0, and the remaining s_* outputs SHALL be 0.
REQ-010 Fixed priority (RR_EN=0): the lowest requesting index SHALL win; master 0 is highest.
REQ-011 Round-robin (RR_EN=1): a registered pointer last_q SHALL hold the last granted index; the search starts at last_q+1 and wraps modulo NUM_MASTERS; last_q updates only on a grant.
REQ-012 A master SHALL hold req and fields stable until its ack; the arbiter does not buffer requests.
REQ-013 Accepted read by master g in cycle t SHALL assert m_resp_o[g]=1 in cycle t+1 with m_rdata_bo = s_rdata_bi; m_resp_o is 0 otherwise.
REQ-014 Back-to-back reads from different masters in consecutive cycles SHALL each return in order on the following cycle; no bubbles are inserted.
REQ-015 A write SHALL produce an ack only, never m_resp_o.
REQ-016 m_rdata_bo SHALL equal s_rdata_bi unconditionally; only m_resp_o qualifies it.

Reset
REQ-017 While rst_i=0, s_req_o, all s_* outputs, m_ack_o and m_resp_o SHALL be 0, regardless of m_req_i.
REQ-018 Reset SHALL set last_q to NUM_MASTERS-1, so master 0 wins first after reset in both modes, and SHALL clear the pending-response register.
REQ-019 A read accepted in the cycle reset asserts SHALL produce no m_resp_o.

Configuration
REQ-020 With macro MEM_ARB_LOCK_EN defined, input m_lock_i [NUM_MASTERS-1:0] SHALL exist: if master g was granted in the previous cycle and m_req_i[g] & m_lock_i[g] are both 1, g SHALL be granted again, overriding priority or round-robin.
REQ-021 Under MEM_ARB_LOCK_EN, lock SHALL release the cycle m_req_i[g] or m_lock_i[g] drops; lock state SHALL reset to none.
REQ-022 Without MEM_ARB_LOCK_EN, m_lock_i SHALL be absent and no grant holding occurs.

Verification
REQ-023 NUM_MASTERS=2, RR_EN=0: m0 and m1 request reads continuously -> m0 acked every cycle, m1 never; m_resp_o[0] pulses one cycle after each ack.
REQ-024 NUM_MASTERS=4, RR_EN=1, all request from reset -> grant order 0,1,2,3,0; last_q wraps 3->0.
REQ-025 m1 reads 0x10 in cycle t, m0 reads 0x20 in t+1, slave returns 0xAAAA0010 then 0xBBBB0020 -> m_resp_o=2'b10 with 0xAAAA0010, then 2'b01 with 0xBBBB0020.
REQ-026 m0 writes 0x0000_0008 data 0xDEADBEEF be 4'h3 -> s_* mirror the values in the same cycle, m_ack_o[0]=1, no m_resp_o.
REQ-027 rst_i driven low while m0 read is accepted -> m_resp_o stays 0 next cycle; after release, first grant goes to master 0.
REQ-028 MEM_ARB_LOCK_EN, RR_EN=1: m2 requests with lock for 3 cycles while m0 and m1 request -> m2 granted 3 consecutive cycles, then m0.
